// File: rtl/ebike_pkg.sv
// Shared types and constants for the eBike assist-current path.
// Holds the FSM/mode enums, the default thresholds and the incline-factor helper.
package ebike_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_PROD,
        S_GAIN,
        S_UPD
    } state_t;

    typedef enum logic [1:0] {
        M_OFF,
        M_ECO,
        M_NORMAL,
        M_BOOST
    } assist_mode_t;

    localparam logic [11:0] TORQUE_MIN = 12'h380;
    localparam logic [4:0]  CAD_MIN    = 5'd2;
    localparam int          INC_OFFSET = 256;

    // Saturating incline to 10b and adding the offset is the same as
    // clamping incline+offset into [0, 511].
    function automatic logic [8:0] inc_factor(input logic signed [12:0] inc);
        logic signed [13:0] s;
        s = $signed({inc[12], inc}) + $signed(14'(INC_OFFSET));
        if (s[13])
            inc_factor = 9'd0;
        else if (s > 14'sd511)
            inc_factor = 9'd511;
        else
            inc_factor = s[8:0];
    endfunction

endpackage

// File: rtl/drive_slew_limiter.sv
// Combinational slew limiter for the assist target current.
// Ports: i_goal, i_target, i_ramp_up, i_ramp_dn, i_bypass (force 0) -> o_next.
module drive_slew_limiter (
    input  logic [11:0] i_goal,
    input  logic [11:0] i_target,
    input  logic [11:0] i_ramp_up,
    input  logic [11:0] i_ramp_dn,
    input  logic        i_bypass,
    output logic [11:0] o_next
);

    logic [11:0] w_diff;

    always_comb begin
        w_diff = '0;
        o_next = i_target;
        if (i_bypass) begin
            o_next = '0;
        end else if (i_goal > i_target) begin
            w_diff = i_goal - i_target;
            o_next = i_target + ((w_diff > i_ramp_up) ? i_ramp_up : w_diff);
        end else begin
            w_diff = i_target - i_goal;
            o_next = i_target - ((w_diff > i_ramp_dn) ? i_ramp_dn : w_diff);
        end
    end

endmodule

// File: rtl/desired_drive_ramped.sv
// Assist-current calculator: torque x scale x incline x cadence, mode gain, slew.
// Ports: clk, rst_n, vld_in + sensor inputs -> target_curr, vld_out, busy, sat.
module desired_drive_ramped #(
    parameter logic [11:0] TORQUE_MIN = ebike_pkg::TORQUE_MIN,
    parameter logic [4:0]  CAD_MIN    = ebike_pkg::CAD_MIN,
    parameter logic [11:0] RAMP_UP    = 12'd64,
    parameter logic [11:0] RAMP_DN    = 12'd256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld_in,
    input  logic [11:0]        avg_torque,
    input  logic [4:0]         cadence,
    input  logic               not_pedaling,
    input  logic signed [12:0] incline,
    input  logic [2:0]         scale,
    input  logic [1:0]         mode,
    output logic [11:0]        target_curr,
    output logic               vld_out,
    output logic               busy,
    output logic               sat
);

    import ebike_pkg::*;

    state_t              r_state;
    logic [11:0]         r_torque;
    logic [4:0]          r_cad;
    logic                r_np;
    logic signed [12:0]  r_inc;
    logic [2:0]          r_scale;
    assist_mode_t        r_mode;
    logic [14:0]         r_p1;
    logic [14:0]         r_p2;
    logic [29:0]         r_prod;
    logic [11:0]         r_goal;
    logic                r_sat_pend;
    logic [11:0]         r_target;
    logic                r_vld;
    logic                r_busy;
    logic                r_sat;

    logic [11:0] w_torque_pos;
    logic [5:0]  w_cad_f;
    logic [8:0]  w_inc_f;
    logic        w_ovf;
    logic [11:0] w_raw;
    logic [12:0] w_boost;
    logic [11:0] w_moded;
    logic        w_clip;
    logic [11:0] w_next;

    assign w_torque_pos = (r_torque > TORQUE_MIN) ? r_torque - TORQUE_MIN : '0;
    assign w_cad_f      = (r_cad >= CAD_MIN) ? {1'b0, r_cad} + 6'd32 : '0;
    assign w_inc_f      = inc_factor(r_inc);

    assign w_ovf   = |r_prod[29:27];
    assign w_raw   = w_ovf ? 12'hFFF : r_prod[26:15];
    assign w_boost = {1'b0, w_raw} + {2'b0, w_raw[11:1]};

    always_comb begin
        w_moded = '0;
        w_clip  = 1'b0;
        unique case (r_mode)
            M_OFF:    w_moded = '0;
            M_ECO:    w_moded = {1'b0, w_raw[11:1]};
            M_NORMAL: w_moded = w_raw;
            M_BOOST: begin
                w_clip  = w_boost[12];
                w_moded = w_boost[12] ? 12'hFFF : w_boost[11:0];
            end
            default:  w_moded = '0;
        endcase
        if (r_np)
            w_moded = '0;
    end

    drive_slew_limiter u_slew (
        .i_goal    (r_goal),
        .i_target  (r_target),
        .i_ramp_up (RAMP_UP),
        .i_ramp_dn (RAMP_DN),
        .i_bypass  (r_np),
        .o_next    (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_torque   <= '0;
            r_cad      <= '0;
            r_np       <= 1'b0;
            r_inc      <= '0;
            r_scale    <= '0;
            r_mode     <= M_OFF;
            r_p1       <= '0;
            r_p2       <= '0;
            r_prod     <= '0;
            r_goal     <= '0;
            r_sat_pend <= 1'b0;
            r_target   <= '0;
            r_vld      <= 1'b0;
            r_busy     <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (vld_in) begin
                        r_torque <= avg_torque;
                        r_cad    <= cadence;
                        r_np     <= not_pedaling;
                        r_inc    <= incline;
                        r_scale  <= scale;
                        r_mode   <= assist_mode_t'(mode);
                        r_busy   <= 1'b1;
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_p1    <= 15'(w_torque_pos) * 15'(r_scale);
                    r_p2    <= 15'(w_inc_f) * 15'(w_cad_f);
                    r_state <= S_PROD;
                end
                S_PROD: begin
                    r_prod  <= 30'(r_p1) * 30'(r_p2);
                    r_state <= S_GAIN;
                end
                S_GAIN: begin
                    r_goal     <= w_moded;
                    r_sat_pend <= w_ovf | w_clip;
                    r_state    <= S_UPD;
                end
                S_UPD: begin
                    r_target <= w_next;
                    r_sat    <= r_sat_pend;
                    r_vld    <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign target_curr = r_target;
    assign vld_out     = r_vld;
    assign busy        = r_busy;
    assign sat         = r_sat;

endmodule

// File: tb/tb_desired_drive_ramped.sv
// Self-checking bench for desired_drive_ramped.
// Directed samples, a cycle-level reference model and literal spot checks.
module tb_desired_drive_ramped;

    logic               clk;
    logic               rst_n;
    logic               vld_in;
    logic [11:0]        avg_torque;
    logic [4:0]         cadence;
    logic               not_pedaling;
    logic signed [12:0] incline;
    logic [2:0]         scale;
    logic [1:0]         mode;
    logic [11:0]        target_curr;
    logic               vld_out;
    logic               busy;
    logic               sat;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    desired_drive_ramped dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_in       (vld_in),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      (incline),
        .scale        (scale),
        .mode         (mode),
        .target_curr  (target_curr),
        .vld_out      (vld_out),
        .busy         (busy),
        .sat          (sat)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Goal and saturation straight from the arithmetic definition.
    function automatic void model_goal(
        input logic [11:0] a, input logic [4:0] c, input logic np,
        input logic signed [12:0] inc, input logic [2:0] s, input logic [1:0] m,
        output int goal, output bit st);
        longint t, ic, cf, prod;
        int raw;
        t = longint'(a) - 896;
        if (t < 0) t = 0;
        ic = longint'(inc) + 256;
        if (ic < 0) ic = 0;
        if (ic > 511) ic = 511;
        cf = (c >= 2) ? longint'(c) + 32 : 0;
        prod = t * longint'(s) * ic * cf;
        st = (prod >= (longint'(1) << 27));
        raw = st ? 4095 : int'(prod >> 15);
        case (m)
            2'd0: goal = 0;
            2'd1: goal = raw / 2;
            2'd2: goal = raw;
            default: begin
                goal = raw + raw / 2;
                if (goal > 4095) begin
                    goal = 4095;
                    st = 1;
                end
            end
        endcase
        if (np) goal = 0;
    endfunction

    int exp_t, exp_vld, exp_sat, cnt;
    int pend_goal;
    bit pend_sat, pend_np;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt = 0; exp_t = 0; exp_vld = 0; exp_sat = 0;
        end else begin
            exp_vld = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (pend_np)
                        exp_t = 0;
                    else if (pend_goal > exp_t)
                        exp_t += (pend_goal - exp_t > 64) ? 64 : pend_goal - exp_t;
                    else
                        exp_t -= (exp_t - pend_goal > 256) ? 256 : exp_t - pend_goal;
                    exp_sat = pend_sat;
                    exp_vld = 1;
                end
            end else if (vld_in) begin
                model_goal(avg_torque, cadence, not_pedaling, incline, scale, mode,
                           pend_goal, pend_sat);
                pend_np = not_pedaling;
                cnt = 4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("model_target", int'(target_curr), exp_t);
            chk("model_vld", int'(vld_out), exp_vld);
            chk("model_busy", int'(busy), int'(cnt != 0));
            chk("model_sat", int'(sat), exp_sat);
        end
    end

    task automatic scramble();
        avg_torque   = 12'($urandom);
        cadence      = 5'($urandom);
        not_pedaling = 1'($urandom);
        incline      = 13'($urandom);
        scale        = 3'($urandom);
        mode         = 2'($urandom);
    endtask

    task automatic send(input logic [11:0] a, input logic [4:0] c, input logic np,
                        input logic signed [12:0] inc, input logic [2:0] s,
                        input logic [1:0] m);
        int lat;
        @(negedge clk);
        avg_torque = a; cadence = c; not_pedaling = np;
        incline = inc; scale = s; mode = m;
        vld_in = 1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                vld_in = 0;
                scramble();
            end
            if (vld_out) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, 5);
    endtask

    int pulses, first_p, second_p;

    initial begin
        rst_n = 0; vld_in = 0;
        avg_torque = 0; cadence = 0; not_pedaling = 0;
        incline = 0; scale = 0; mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_target", int'(target_curr), 0);
        chk("rst_vld", int'(vld_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sat", int'(sat), 0);
        #2 rst_n = 1;
        chk_en = 1;

        // Ramp-up from zero, raw = 252
        send(12'h480, 5'd3 + 5'd7, 0, 13'sd0, 3'd3, 2'd2);
        chk("ramp1", int'(target_curr), 64);
        send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd2);
        chk("ramp2", int'(target_curr), 128);
        send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd2);
        chk("ramp3", int'(target_curr), 192);
        send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd2);
        chk("ramp4", int'(target_curr), 252);

        // ECO halves, BOOST x1.5
        send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd1);
        chk("eco", int'(target_curr), 126);
        repeat (4) send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd3);
        chk("boost", int'(target_curr), 378);
        chk("boost_sat", int'(sat), 0);

        // Product overflow
        send(12'hFFF, 5'd31, 0, 13'sd511, 3'd7, 2'd2);
        chk("sat_t1", int'(target_curr), 442);
        chk("sat_flag", int'(sat), 1);
        send(12'hFFF, 5'd31, 0, 13'sd511, 3'd7, 2'd2);
        chk("sat_t2", int'(target_curr), 506);
        send(12'hFFF, 5'd31, 0, -13'sd4096, 3'd7, 2'd2);
        chk("inc_min", int'(target_curr), 250);
        chk("inc_min_sat", int'(sat), 0);

        // not_pedaling bypass
        send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd2);
        chk("np_pre", int'(target_curr), 252);
        send(12'h480, 5'd10, 1, 13'sd0, 3'd3, 2'd2);
        chk("np_zero", int'(target_curr), 0);

        // Climb to 600, then OFF ramps down
        repeat (10) send(12'h500, 5'd8, 0, 13'sd0, 3'd5, 2'd2);
        chk("goal600", int'(target_curr), 600);
        send(12'h500, 5'd8, 0, 13'sd0, 3'd5, 2'd0);
        chk("off1", int'(target_curr), 344);
        send(12'h500, 5'd8, 0, 13'sd0, 3'd5, 2'd0);
        chk("off2", int'(target_curr), 88);
        send(12'h500, 5'd8, 0, 13'sd0, 3'd5, 2'd0);
        chk("off3", int'(target_curr), 0);

        // vld_in while busy is dropped; N+5 is accepted
        @(negedge clk);
        avg_torque = 12'h480; cadence = 5'd10; not_pedaling = 0;
        incline = 0; scale = 3'd3; mode = 2'd2;
        vld_in = 1;
        pulses = 0; first_p = -1; second_p = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vld_in = (i == 2 || i == 4 || i == 5);
            if (i == 3) chk("busy_mid", int'(busy), 1);
            if (vld_out) begin
                pulses++;
                if (first_p < 0) first_p = i;
                else second_p = i;
            end
        end
        chk("busy_pulses", pulses, 2);
        chk("busy_first", first_p, 5);
        chk("busy_second", second_p, 10);

        // Reset mid-operation
        @(negedge clk);
        vld_in = 1;
        @(negedge clk);
        vld_in = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_target", int'(target_curr), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_sat", int'(sat), 0);
        chk("mid_rst_vld", int'(vld_out), 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vld_out) pulses++;
        end
        #2 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vld_out) pulses++;
        end
        chk("mid_rst_no_vld", pulses, 0);
        send(12'h480, 5'd10, 0, 13'sd0, 3'd3, 2'd2);
        chk("post_rst", int'(target_curr), 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
